// File: rtl/rst_seq.sv
// Reset sequencer: holds system reset until PLL lock is stable, then releases after a hold time.
// Optional RST_CAUSE_EN macro adds a 2-bit rst_cause register/port recording the last reset cause.
module rst_seq #(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_ok,
  input  logic       rst_btn_n,
  input  logic       rst_req,
  output logic       rst_out,
  output logic       rst_out_n,
`ifdef RST_CAUSE_EN
  output logic       ready,
  output logic [1:0] rst_cause
`else
  output logic       ready
`endif
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [HW-1:0]          hold_cnt;
  logic [HW-1:0]          hold_nxt;
  logic [DW-1:0]          deb_cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   btn_s;
  logic                   btn_valid;
`ifdef RST_CAUSE_EN
  logic [1:0]             cause_nxt;
`endif

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign btn_s     = btn_sync[SYNC_STAGES-1];
  assign btn_valid = (deb_cnt == DW'(DEBOUNCE_CYCLES));

  // Synchronisers for the asynchronous lock and button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      btn_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], clk_ok};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], ~rst_btn_n};
    end
  end

  // Debounce: saturating count of consecutive pressed samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
    end else if (!btn_s) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DW'(DEBOUNCE_CYCLES)) begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      rst_out   <= 1'b1;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
`ifdef RST_CAUSE_EN
      rst_cause <= 2'd0;
`endif
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      rst_out   <= (state_nxt != RUN);
      rst_out_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
`ifdef RST_CAUSE_EN
      rst_cause <= cause_nxt;
`endif
    end
  end

  // Next-state logic; button priority over rst_req when leaving RUN
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
`ifdef RST_CAUSE_EN
    cause_nxt = rst_cause;
`endif
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          hold_nxt  = '0;
`ifdef RST_CAUSE_EN
          cause_nxt = 2'd0;
`endif
        end else if (btn_valid) begin
          hold_nxt = '0;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          hold_nxt  = '0;
`ifdef RST_CAUSE_EN
          cause_nxt = 2'd0;
`endif
        end else if (btn_valid) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
`ifdef RST_CAUSE_EN
          cause_nxt = 2'd1;
`endif
        end else if (rst_req) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
`ifdef RST_CAUSE_EN
          cause_nxt = 2'd2;
`endif
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        hold_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with HOLD_CYCLES=4, DEBOUNCE_CYCLES=3, SYNC_STAGES=2.
// Define RST_CAUSE_EN on both files to also check rst_cause.
module tb_rst_seq;

  localparam logic [2:0] V_RST = 3'b100;  // {rst_out, rst_out_n, ready}
  localparam logic [2:0] V_RUN = 3'b011;

  logic clk = 1'b0;
  logic rst, clk_ok, rst_btn_n, rst_req;
  logic rst_out, rst_out_n, ready;
`ifdef RST_CAUSE_EN
  logic [1:0] rst_cause;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rst_seq #(
    .HOLD_CYCLES    (4),
    .DEBOUNCE_CYCLES(3),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_ok   (clk_ok),
    .rst_btn_n(rst_btn_n),
    .rst_req  (rst_req),
    .rst_out  (rst_out),
    .rst_out_n(rst_out_n),
`ifdef RST_CAUSE_EN
    .ready    (ready),
    .rst_cause(rst_cause)
`else
    .ready    (ready)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs changed afterwards are sampled at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; outputs show reset for edges e with rs <= e < re, run otherwise
  task automatic watch(input string tag, input int n, input int rs, input int re);
    for (int e = 1; e <= n; e++) begin
      tick();
      check($sformatf("%s_e%0d", tag, e), 32'({rst_out, rst_out_n, ready}),
            (e >= rs && e < re) ? 32'(V_RST) : 32'(V_RUN));
    end
  endtask

  initial begin
    rst = 1'b1; clk_ok = 1'b0; rst_btn_n = 1'b1; rst_req = 1'b0;
    watch("reset", 3, 0, 1000);
`ifdef RST_CAUSE_EN
    check("cause_reset", 32'(rst_cause), 32'd0);
`endif
    rst = 1'b0;
    watch("no_lock", 100, 0, 1000);

    clk_ok = 1'b1;
    watch("lock", 8, 0, 7);
`ifdef RST_CAUSE_EN
    check("cause_powerup", 32'(rst_cause), 32'd0);
`endif

    rst_btn_n = 1'b0;
    tick(); tick();
    rst_btn_n = 1'b1;
    watch("btn_short", 10, 1000, 1000);

    rst_btn_n = 1'b0;
    watch("btn_hold", 10, 6, 1000);
    rst_btn_n = 1'b1;
    watch("btn_release", 10, 0, 7);
`ifdef RST_CAUSE_EN
    check("cause_btn", 32'(rst_cause), 32'd1);
`endif

    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    check("req_e1", 32'({rst_out, rst_out_n, ready}), 32'(V_RST));
    watch("req_hold", 5, 0, 4);
`ifdef RST_CAUSE_EN
    check("cause_req", 32'(rst_cause), 32'd2);
`endif

    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    check("req_in_hold_e3", 32'({rst_out, rst_out_n, ready}), 32'(V_RST));
    watch("req_in_hold", 3, 0, 2);

    clk_ok = 1'b0;
    watch("loss_run", 3, 3, 1000);
    watch("wait_lock", 5, 0, 1000);
`ifdef RST_CAUSE_EN
    check("cause_loss", 32'(rst_cause), 32'd0);
`endif
    clk_ok = 1'b1;
    watch("relock", 3, 0, 1000);
    clk_ok = 1'b0;
    watch("loss_hold", 6, 0, 1000);
    clk_ok = 1'b1;
    watch("relock2", 8, 0, 7);
`ifdef RST_CAUSE_EN
    check("cause_relock", 32'(rst_cause), 32'd0);
`endif

    rst_btn_n = 1'b0;
    watch("combo_pre", 5, 1000, 1000);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    rst_btn_n = 1'b1;
    check("combo_edge", 32'({rst_out, rst_out_n, ready}), 32'(V_RST));
`ifdef RST_CAUSE_EN
    check("cause_combo", 32'(rst_cause), 32'd1);
`endif
    watch("combo_hold", 4, 0, 1000);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_hold_rst", 32'({rst_out, rst_out_n, ready}), 32'(V_RST));
`ifdef RST_CAUSE_EN
    check("cause_mid_rst", 32'(rst_cause), 32'd0);
`endif
    watch("post_rst", 8, 0, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
